// File: rtl/ads_adc_multi_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-channel ADS8321-class ADC controller.
package ads_adc_multi_ctrl_pkg;

   // Frame sequencer states: idle, serial conversion, CSN-high recovery.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_RECOV = 2'd2
   } adc_state_e;

   // Number of DCLK rising edges in one frame: lead-in (sample + null bit) plus data bits.
   function automatic int frame_len(input int lead_clks, input int data_w);
      return lead_clks + data_w;
   endfunction

   // Counter width able to hold the value n (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ads_adc_multi_ctrl_dclk_gen.sv
// DCLK generator: registered divide-by-(2*CLK_DIV) clock with rise/fall strobes.
// Runs only while enabled; otherwise DCLK is parked low and the divider is cleared,
// so the first rising edge always lands CLK_DIV clocks after enable goes high.
module ads_adc_multi_ctrl_dclk_gen
   import ads_adc_multi_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic dclk,
   output logic rise,
   output logic fall
);

   localparam int DIV_W = cnt_width(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   logic [DIV_W-1:0] half_cnt_r;
   logic             dclk_r;
   logic             tick_s;

   // Half-period boundary detection and edge strobes for the next clk edge.
   always_comb begin
      tick_s = 1'b0;
      rise   = 1'b0;
      fall   = 1'b0;
      if (en) begin
         tick_s = (half_cnt_r == DIV_LAST);
         rise   = tick_s & ~dclk_r;
         fall   = tick_s & dclk_r;
      end else begin
         tick_s = 1'b0;
      end
   end

   // Half-period counter and DCLK register; both held at zero while disabled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         half_cnt_r <= DIV_ZERO;
         dclk_r     <= 1'b0;
      end else if (!en) begin
         half_cnt_r <= DIV_ZERO;
         dclk_r     <= 1'b0;
      end else if (tick_s) begin
         half_cnt_r <= DIV_ZERO;
         dclk_r     <= ~dclk_r;
      end else begin
         half_cnt_r <= half_cnt_r + DIV_ONE;
      end
   end

   assign dclk = dclk_r;

endmodule

// File: rtl/ads_adc_multi_ctrl.sv
// Controller for NUM_CH ADS8321-class serial SAR ADCs sharing DCLK/CSN.
// All DOUT lines are captured in parallel on each DCLK rising edge; the first
// LEAD_CLKS samples are discarded and the next DATA_W form the MSB-first result.
// Triggers come from ad_start or a free-running period timer; triggers that arrive
// while busy (conversion or CSN recovery) are dropped and flagged on ad_ovr.
module ads_adc_multi_ctrl
   import ads_adc_multi_ctrl_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 16,
   parameter int LEAD_CLKS = 6,
   parameter int CLK_DIV   = 1,
   parameter int CSN_HIGH  = 2,
   parameter int PERIOD_W  = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       ad_start,
   input  logic                       ad_cont,
   input  logic [PERIOD_W-1:0]        ad_period,
   output logic                       ad_busy,
   output logic                       ad_dval,
   output logic                       ad_ovr,
   input  logic [NUM_CH-1:0]          ad_dout,
   output logic                       ad_dclk,
   output logic                       ad_csn,
   output logic [NUM_CH*DATA_W-1:0]   ad_data
);

   localparam int FRAME  = frame_len(LEAD_CLKS, DATA_W);
   localparam int BCNT_W = cnt_width(FRAME);
   localparam int REC_W  = cnt_width(CSN_HIGH);

   localparam logic [BCNT_W-1:0]   BCNT_ZERO  = {BCNT_W{1'b0}};
   localparam logic [BCNT_W-1:0]   BCNT_ONE   = BCNT_W'(1);
   localparam logic [BCNT_W-1:0]   BCNT_LEAD  = BCNT_W'(LEAD_CLKS);
   localparam logic [BCNT_W-1:0]   BCNT_FRAME = BCNT_W'(FRAME);
   localparam logic [REC_W-1:0]    REC_ZERO   = {REC_W{1'b0}};
   localparam logic [REC_W-1:0]    REC_ONE    = REC_W'(1);
   localparam logic [REC_W-1:0]    REC_LAST   = REC_W'(CSN_HIGH - 1);
   localparam logic [PERIOD_W-1:0] PER_ZERO   = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] PER_ONE    = PERIOD_W'(1);
   localparam logic [NUM_CH*DATA_W-1:0] DATA_ZERO = {(NUM_CH*DATA_W){1'b0}};

   adc_state_e                  state_r;
   logic                        busy_r;
   logic                        dval_r;
   logic                        ovr_r;
   logic                        csn_r;
   logic [NUM_CH*DATA_W-1:0]    data_r;
   logic [BCNT_W-1:0]           bit_cnt_r;
   logic [REC_W-1:0]            rec_cnt_r;
   logic [PERIOD_W-1:0]         timer_r;
   logic [PERIOD_W-1:0]         period_r;

   logic                        conv_s;
   logic                        dclk_s;
   logic                        rise_s;
   logic                        fall_s;
   logic                        timer_hit_s;
   logic                        trig_s;
   logic                        capture_s;
   logic [NUM_CH*DATA_W-1:0]    shift_pack_s;

   // Trigger sources and capture qualifier for the shift registers.
   always_comb begin
      conv_s      = (state_r == ST_CONV);
      timer_hit_s = 1'b0;
      if (ad_cont && (period_r != PER_ZERO)) begin
         timer_hit_s = (timer_r == (period_r - PER_ONE));
      end else begin
         timer_hit_s = 1'b0;
      end
      trig_s    = ad_start | timer_hit_s;
      capture_s = rise_s & (bit_cnt_r >= BCNT_LEAD);
   end

   ads_adc_multi_ctrl_dclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_dclk_gen (
      .clk  (clk),
      .rstn (rstn),
      .en   (conv_s),
      .dclk (dclk_s),
      .rise (rise_s),
      .fall (fall_s)
   );

   // Auto-trigger timer: wraps at period_r-1; period is re-sampled only at wrap or while held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         timer_r  <= PER_ZERO;
         period_r <= PER_ZERO;
      end else if (!ad_cont || (ad_period == PER_ZERO)) begin
         timer_r  <= PER_ZERO;
         period_r <= ad_period;
      end else if ((period_r == PER_ZERO) || (timer_r == (period_r - PER_ONE))) begin
         timer_r  <= PER_ZERO;
         period_r <= ad_period;
      end else begin
         timer_r  <= timer_r + PER_ONE;
      end
   end

   // Frame sequencer: accept trigger, count DCLK rises, publish result, hold CSN high for recovery.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         busy_r    <= 1'b0;
         dval_r    <= 1'b0;
         ovr_r     <= 1'b0;
         csn_r     <= 1'b1;
         data_r    <= DATA_ZERO;
         bit_cnt_r <= BCNT_ZERO;
         rec_cnt_r <= REC_ZERO;
      end else begin
         dval_r <= 1'b0;
         ovr_r  <= trig_s & busy_r;
         case (state_r)
            ST_IDLE: begin
               if (trig_s) begin
                  state_r   <= ST_CONV;
                  csn_r     <= 1'b0;
                  busy_r    <= 1'b1;
                  bit_cnt_r <= BCNT_ZERO;
               end else begin
                  csn_r     <= 1'b1;
                  busy_r    <= 1'b0;
               end
            end
            ST_CONV: begin
               if (rise_s) begin
                  bit_cnt_r <= bit_cnt_r + BCNT_ONE;
               end else if (fall_s && (bit_cnt_r == BCNT_FRAME)) begin
                  state_r   <= ST_RECOV;
                  csn_r     <= 1'b1;
                  data_r    <= shift_pack_s;
                  dval_r    <= 1'b1;
                  rec_cnt_r <= REC_ZERO;
               end else begin
                  bit_cnt_r <= bit_cnt_r;
               end
            end
            ST_RECOV: begin
               if (rec_cnt_r == REC_LAST) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  rec_cnt_r <= rec_cnt_r + REC_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               csn_r   <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // One MSB-first shift register per DOUT line, filled only after the lead-in rises.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DATA_W-1:0] shift_r;

      // Shift in this channel's DOUT on qualifying DCLK rising edges.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            shift_r <= {DATA_W{1'b0}};
         end else if (capture_s) begin
            shift_r <= {shift_r[DATA_W-2:0], ad_dout[g]};
         end else begin
            shift_r <= shift_r;
         end
      end

      assign shift_pack_s[g*DATA_W +: DATA_W] = shift_r;
   end

   assign ad_busy = busy_r;
   assign ad_dval = dval_r;
   assign ad_ovr  = ovr_r;
   assign ad_dclk = dclk_s;
   assign ad_csn  = csn_r;
   assign ad_data = data_r;

endmodule

// File: tb/tb_ads_adc_multi_ctrl.sv
// Directed bench: two controller instances (2ch/div1 and 1ch/div3) driving simple ADC models.
module tb_ads_adc_multi_ctrl;

   localparam logic [15:0] W0_CH0 = 16'hA5C3;
   localparam logic [15:0] W0_CH1 = 16'h1234;
   localparam logic [15:0] W1_CH0 = 16'h8000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;

   logic        start0 = 1'b0;
   logic        cont0 = 1'b0;
   logic [15:0] period0 = 16'd0;
   logic        busy0, dval0, ovr0, dclk0, csn0;
   logic [1:0]  dout0;
   logic [31:0] data0;

   logic        start1 = 1'b0;
   logic        busy1, dval1, ovr1, dclk1, csn1;
   logic [0:0]  dout1;
   logic [15:0] data1;

   int n_checks = 0;
   int n_fail   = 0;
   int rcnt0 = 0, rcnt1 = 0, rises0 = 0, rises1 = 0;

   ads_adc_multi_ctrl #(.NUM_CH(2), .DATA_W(16), .LEAD_CLKS(6), .CLK_DIV(1), .CSN_HIGH(2), .PERIOD_W(16)) dut0 (
      .clk(clk), .rstn(rstn), .ad_start(start0), .ad_cont(cont0), .ad_period(period0),
      .ad_busy(busy0), .ad_dval(dval0), .ad_ovr(ovr0), .ad_dout(dout0),
      .ad_dclk(dclk0), .ad_csn(csn0), .ad_data(data0));

   ads_adc_multi_ctrl #(.NUM_CH(1), .DATA_W(16), .LEAD_CLKS(6), .CLK_DIV(3), .CSN_HIGH(2), .PERIOD_W(16)) dut1 (
      .clk(clk), .rstn(rstn), .ad_start(start1), .ad_cont(1'b0), .ad_period(16'd0),
      .ad_busy(busy1), .ad_dval(dval1), .ad_ovr(ovr1), .ad_dout(dout1),
      .ad_dclk(dclk1), .ad_csn(csn1), .ad_data(data1));

   always #5 clk = ~clk;

   // ADC model: 6 lead-in bits (driven 1 so they must be discarded), then word MSB first.
   function automatic logic adc_bit(input logic [15:0] w, input int r);
      if (r < 6) return 1'b1;
      else if (r < 22) return w[21 - r];
      else return 1'b0;
   endfunction

   always_comb begin
      dout0[0] = adc_bit(W0_CH0, rcnt0);
      dout0[1] = adc_bit(W0_CH1, rcnt0);
      dout1[0] = adc_bit(W1_CH0, rcnt1);
   end

   always @(posedge dclk0 or posedge csn0) begin
      if (csn0) rcnt0 <= 0;
      else      rcnt0 <= rcnt0 + 1;
   end

   always @(posedge dclk1 or posedge csn1) begin
      if (csn1) rcnt1 <= 0;
      else      rcnt1 <= rcnt1 + 1;
   end

   always @(posedge dclk0) rises0 <= rises0 + 1;
   always @(posedge dclk1) rises1 <= rises1 + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Single-shot frame on dut0; optional extra start pulse driven after cycle poke_at.
   task automatic frame0(input int poke_at, input int ncyc,
                         output int lat, output int ovr_at, output int novr, output int ndv);
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      lat = -1; ovr_at = -1; novr = 0; ndv = 0;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         if (ovr0) begin
            novr++;
            if (ovr_at < 0) ovr_at = n;
         end
         if (dval0) begin
            ndv++;
            if (lat < 0) lat = n;
         end
         start0 = (n == poke_at);
      end
      start0 = 1'b0;
   endtask

   initial begin
      int lat, oa, no, nd, r0, gap, got;
      int times [5];
      logic [5:0] pat;

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // reset state
      check_eq("rst_busy", 64'(busy0), 64'd0);
      check_eq("rst_csn",  64'(csn0),  64'd1);
      check_eq("rst_dclk", 64'(dclk0), 64'd0);
      check_eq("rst_data", 64'(data0), 64'd0);
      check_eq("rst_dval", 64'(dval0), 64'd0);
      check_eq("rst_ovr",  64'(ovr0),  64'd0);

      // single shot, 2 channels, CLK_DIV=1
      r0 = rises0;
      frame0(0, 60, lat, oa, no, nd);
      check_eq("ss_lat",   64'(lat), 64'd44);
      check_eq("ss_data",  64'(data0), 64'h1234_A5C3);
      check_eq("ss_rises", 64'(rises0 - r0), 64'd22);
      check_eq("ss_ndval", 64'(nd), 64'd1);
      check_eq("ss_novr",  64'(no), 64'd0);
      check_eq("ss_idle",  64'({busy0, csn0, dclk0}), 64'b010);

      // single shot, 1 channel, CLK_DIV=3
      r0 = rises1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      pat = 6'd0; lat = -1;
      for (int n = 1; n <= 150; n++) begin
         @(posedge clk); #1;
         if (n <= 6) pat = {pat[4:0], dclk1};
         if (dval1 && lat < 0) lat = n;
      end
      check_eq("div3_lat",   64'(lat), 64'd132);
      check_eq("div3_data",  64'(data1), 64'h8000);
      check_eq("div3_dclk",  64'(pat), 64'b001110);
      check_eq("div3_rises", 64'(rises1 - r0), 64'd22);

      // start during frame -> overrun
      frame0(10, 60, lat, oa, no, nd);
      check_eq("ovr_at",   64'(oa), 64'd11);
      check_eq("ovr_cnt",  64'(no), 64'd1);
      check_eq("ovr_ndv",  64'(nd), 64'd1);
      check_eq("ovr_lat",  64'(lat), 64'd44);
      check_eq("ovr_data", 64'(data0), 64'h1234_A5C3);

      // reset mid-frame
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (20) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check_eq("mrst_csn",  64'(csn0),  64'd1);
      check_eq("mrst_dclk", 64'(dclk0), 64'd0);
      check_eq("mrst_data", 64'(data0), 64'd0);
      check_eq("mrst_busy", 64'(busy0), 64'd0);
      nd = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (dval0) nd++;
      end
      check_eq("mrst_ndv", 64'(nd), 64'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      frame0(0, 60, lat, oa, no, nd);
      check_eq("mrst_lat",  64'(lat), 64'd44);
      check_eq("mrst_fresh", 64'(data0), 64'h1234_A5C3);

      // back-to-back with start held high
      start0 = 1'b1;
      got = 0;
      for (int n = 0; n < 100 && got == 0; n++) begin
         @(posedge clk); #1;
         if (dval0) got = 1;
      end
      check_eq("b2b_first", 64'(got), 64'd1);
      gap = 1; no = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (ovr0) no++;
         if (csn0) gap++;
         else break;
      end
      check_eq("b2b_gap",  64'(gap), 64'd3);
      check_eq("b2b_novr", 64'(no), 64'd2);
      lat = -1;
      for (int n = 1; n <= 60 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (dval0) lat = n;
      end
      start0 = 1'b0;
      check_eq("b2b_lat",  64'(lat), 64'd44);
      check_eq("b2b_data", 64'(data0), 64'h1234_A5C3);
      repeat (10) @(posedge clk);
      #1;

      // free-running, period 100
      period0 = 16'd100;
      @(posedge clk); #1;
      cont0 = 1'b1;
      nd = 0; no = 0;
      for (int n = 1; n <= 600 && nd < 5; n++) begin
         @(posedge clk); #1;
         if (ovr0) no++;
         if (dval0) begin
            times[nd] = n;
            nd++;
         end
      end
      cont0 = 1'b0;
      check_eq("p100_ndv",   64'(nd), 64'd5);
      check_eq("p100_first", 64'(times[0]), 64'd144);
      for (int i = 1; i < 5; i++) check_eq("p100_intv", 64'(times[i] - times[i-1]), 64'd100);
      check_eq("p100_novr", 64'(no), 64'd0);
      repeat (60) @(posedge clk);
      #1;

      // free-running, period 30: every other trigger overruns
      period0 = 16'd30;
      @(posedge clk); #1;
      cont0 = 1'b1;
      nd = 0; no = 0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (ovr0) no++;
         if (dval0) nd++;
      end
      cont0 = 1'b0;
      check_eq("p30_novr", 64'(no), 64'd5);
      check_eq("p30_ndv",  64'(nd), 64'd4);
      repeat (60) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
